rx_buffer: RTL and testbench
============================

Name: rx_buffer

Overview:
- Stage directly downstream of uart_rx. Captures each received byte (one-cycle rcv strobe plus data) into a small circular FIFO.
- Drains the FIFO into uart_tx using its start/ready handshake, giving a lossless echo path that tolerates back-to-back characters while the transmitter is busy.
- Exposes fill level and a sticky overflow flag for LEDs and debug.

Parameters:
- DEPTH_LOG2, 4: log2 of FIFO depth; 4 gives 16 entries.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- rcv  input  1  one-cycle strobe from uart_rx: data_in is valid.
- data_in  input  8  received byte.
- tx_ready  input  1  uart_tx idle; high means it can accept a start.
- tx_start  output  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  output  8  byte to transmit; registered; stable from tx_start until the next tx_start.
- count  output  DEPTH_LOG2+1  number of bytes stored.
- full  output  1  count equals 2^DEPTH_LOG2.
- empty  output  1  count equals 0.
- overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rstn low, asynchronous):
  - Pointers and count go to 0.
  - tx_start=0, tx_data=8'h00, overflow=0, empty=1, full=0.
  - FSM goes to IDLE.
- Reset mid-transfer discards all stored bytes. A pending tx_start is cancelled immediately.
- Write:
  - On a clock edge with rcv=1, store data_in at wr_ptr and increment wr_ptr.
  - Pointers are DEPTH_LOG2 bits and wrap modulo depth.
  - If full and no pop in the same cycle: drop the byte and set overflow=1. overflow clears only on reset.
- Simultaneous write and pop:
  - When full: the write is accepted and count is unchanged.
  - When empty: only the write happens; a pop requires count>0 at the start of the cycle.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE (and SEND_LF, only with the optional feature).
  - IDLE: if !empty and tx_ready, then at the clock edge set tx_start=1, load tx_data with mem[rd_ptr], increment rd_ptr, decrement count, and go to WAIT_BUSY.
  - WAIT_BUSY: tx_start returns to 0 (always exactly one cycle high). Stay until tx_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_ready=1, then go to IDLE.
- Latency: with the FSM in IDLE, FIFO empty and tx_ready=1, rcv high in cycle 0 gives tx_start high in cycle 2.
- Throughput: at most one byte per uart_tx frame. Writes continue at any rate during transmission.
- Bookkeeping:
  - count is updated in the same edge as the pointer moves.
  - full and empty are derived combinationally from count.
- tx_start is never asserted while tx_ready=0.

Optional Feature:
- Macro: RX_BUFFER_CRLF_EN.
- Defined: when WAIT_DONE completes and the last transmitted byte was 8'h0D, go to SEND_LF instead of IDLE.
  - SEND_LF: once tx_ready=1, pulse tx_start with tx_data=8'h0A without popping the FIFO, then WAIT_BUSY, WAIT_DONE, IDLE.
  - If the sent 8'h0A is followed by a stored 8'h0A, that byte is still sent.
- Undefined: SEND_LF does not exist; bytes pass through unmodified.

Decomposition:
- Package rx_buffer_pkg holds:
  - the state enum (IDLE, WAIT_BUSY, WAIT_DONE, SEND_LF);
  - CHAR_CR=8'h0D and CHAR_LF=8'h0A.
- Sub-module fifo_sync: storage array, pointers, count, full/empty; ports push/pop/wdata/rdata.
- rx_buffer holds the FSM, overflow flag and tx registers.

Test Plan:
- Single byte: rcv pulse with 8'h41, tx_ready=1 -> tx_start one cycle wide 2 cycles later, tx_data=8'h41, count returns to 0.
- Burst while busy: hold tx_ready=0 and write 8'h31..8'h35 -> count=5, no tx_start. Release tx_ready, model a frame per start -> 8'h31..8'h35 sent in order, empty=1 at end.
- Overflow: tx_ready=0 and write 17 bytes with DEPTH_LOG2=4 -> full=1, count=16, overflow=1. The 17th byte is never transmitted.
- Full plus pop: FIFO full, tx_ready rises, and an rcv of 8'h7A arrives in the tx_start cycle -> byte accepted, count stays 16, overflow stays 0.
- Reset mid-operation: 3 bytes stored, rstn low during WAIT_BUSY -> count=0, tx_start=0, tx_data=8'h00, FSM IDLE, no further starts.
- CRLF (macro defined): write 8'h0D, 8'h42 -> transmitted 8'h0D, 8'h0A, 8'h42. Macro undefined -> 8'h0D, 8'h42.

Source files
------------

// File: rtl/rx_buffer_pkg.sv
// rtl/rx_buffer_pkg.sv - shared types and constants for rx_buffer (RX_BUFFER_CRLF_EN adds LF insertion)
package rx_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    SEND_LF   = 2'd3
  } state_t;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

endpackage

// File: rtl/rx_buffer_fifo_sync.sv
// rtl/rx_buffer_fifo_sync.sv - circular byte FIFO with count, full and empty
module fifo_sync #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // A pop needs a byte present at the start of the cycle; a push into a
  // full FIFO is only taken when the same edge frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Storage array: written only when a push is accepted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally at DEPTH; count moves on the same edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_buffer.sv
// rtl/rx_buffer.sv - uart_rx to uart_tx echo buffer; RX_BUFFER_CRLF_EN sends LF after each CR
module rx_buffer
  import rx_buffer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                rcv,
  input  logic [7:0]          data_in,
  input  logic                tx_ready,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                overflow
);

  state_t     state;
  state_t     state_next;
  logic       tx_start_next;
  logic [7:0] tx_data_next;
  logic       pop;
  logic [7:0] rdata;

  fifo_sync #(
    .DEPTH_LOG2(DEPTH_LOG2),
    .WIDTH     (8)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (rcv),
    .pop  (pop),
    .wdata(data_in),
    .rdata(rdata),
    .count(count),
    .full (full),
    .empty(empty)
  );

  // Transmit sequencer: one start per uart_tx frame, waiting for the
  // transmitter to go busy and then idle again before the next byte.
  always_comb begin
    state_next    = state;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          pop           = 1'b1;
          tx_start_next = 1'b1;
          tx_data_next  = rdata;
          state_next    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!tx_ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_ready) begin
`ifdef RX_BUFFER_CRLF_EN
          state_next = (tx_data == CHAR_CR) ? SEND_LF : IDLE;
`else
          state_next = IDLE;
`endif
        end
      end
`ifdef RX_BUFFER_CRLF_EN
      SEND_LF: begin
        // The inserted LF is not taken from the FIFO; tx_data then holds
        // LF, so a following CR check cannot loop back here.
        if (tx_ready) begin
          tx_start_next = 1'b1;
          tx_data_next  = CHAR_LF;
          state_next    = WAIT_BUSY;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and transmit registers; reset cancels any pending start at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      state    <= state_next;
      tx_start <= tx_start_next;
      tx_data  <= tx_data_next;
    end
  end

  // Sticky drop flag: a byte arrived while full and nothing left this cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (rcv && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rx_buffer.sv
// tb/tb_rx_buffer.sv - randomized and directed bench for rx_buffer with a queue reference model
module tb_rx_buffer;

  localparam int DL2   = 4;
  localparam int DEPTH = 1 << DL2;

  logic         clk = 1'b0;
  logic         rstn;
  logic         rcv;
  logic [7:0]   data_in;
  logic         tx_ready;
  logic         tx_start;
  logic [7:0]   tx_data;
  logic [DL2:0] count;
  logic         full;
  logic         empty;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  logic [7:0] q[$];
  logic [7:0] sent[$];
  bit         hold;
  bit         accept_pending;
  bit         lf_pending;
  bit         ovf;
  bit         prev_start;
  int         busy;
  logic [7:0] last_tx;

  rx_buffer #(.DEPTH_LOG2(DL2)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rcv     (rcv),
    .data_in (data_in),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .count   (count),
    .full    (full),
    .empty   (empty),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    accept_pending = 1'b0;
    lf_pending     = 1'b0;
    ovf            = 1'b0;
    prev_start     = 1'b0;
    busy           = 0;
    last_tx        = 8'h00;
  endtask

  // One clock: drive inputs, let the edge pass, then score the outputs.
  // The uart_tx model keeps ready high until it has sampled a start, then
  // stays busy for a random frame length.
  task automatic tick(input bit r, input logic [7:0] d);
    bit         rdy_pre;
    int         size_pre;
    bit         popped;
    logic [7:0] exp_byte;
    rcv      = r;
    data_in  = d;
    tx_ready = accept_pending || (busy == 0 && !hold);
    rdy_pre  = tx_ready;
    size_pre = q.size();
    popped   = 1'b0;
    @(posedge clk);
    #1;
    if (tx_start) begin
      check("start_needs_ready", 32'(rdy_pre), 32'd1);
      check("start_one_cycle", 32'(prev_start), 32'd0);
      if (lf_pending) begin
        exp_byte   = 8'h0A;
        lf_pending = 1'b0;
      end else begin
        check("start_has_data", 32'(size_pre != 0), 32'd1);
        exp_byte = (size_pre != 0) ? q.pop_front() : 8'hxx;
        popped   = 1'b1;
`ifdef RX_BUFFER_CRLF_EN
        if (exp_byte == 8'h0D) lf_pending = 1'b1;
`endif
      end
      check("tx_data_at_start", 32'(tx_data), 32'(exp_byte));
      last_tx = exp_byte;
      sent.push_back(tx_data);
      accept_pending = 1'b1;
    end else begin
      check("tx_data_stable", 32'(tx_data), 32'(last_tx));
      if (accept_pending) begin
        accept_pending = 1'b0;
        busy           = 2 + int'($urandom_range(0, 4));
      end else if (busy > 0) begin
        busy--;
      end
    end
    if (r) begin
      if (size_pre < DEPTH || popped) q.push_back(d);
      else ovf = 1'b1;
    end
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(ovf));
    prev_start = tx_start;
    rcv        = 1'b0;
  endtask

  task automatic drain();
    hold = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (q.size() == 0 && !lf_pending && busy == 0 && !accept_pending) break;
      tick(1'b0, 8'h00);
    end
    check("drain_done", 32'(q.size()), 32'd0);
    repeat (3) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_clear();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn     = 1'b0;
    rcv      = 1'b0;
    data_in  = 8'h00;
    tx_ready = 1'b1;
    hold     = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single byte: start two cycles after rcv, one cycle wide.
    tick(1'b1, 8'h41);
    check("lat_no_start_c1", 32'(tx_start), 32'd0);
    tick(1'b0, 8'h00);
    check("lat_start_c2", 32'(tx_start), 32'd1);
    check("lat_data", 32'(tx_data), 32'h41);
    check("lat_count0", 32'(count), 32'd0);
    tick(1'b0, 8'h00);
    check("lat_start_low", 32'(tx_start), 32'd0);
    drain();

    // Burst while the transmitter is held busy.
    sent.delete();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'h31 + 8'(i));
    check("burst_count", 32'(count), 32'd5);
    check("burst_no_start", 32'(sent.size()), 32'd0);
    drain();
    check("burst_sent_n", 32'(sent.size()), 32'd5);
    for (int i = 0; i < 5 && i < sent.size(); i++) check("burst_order", 32'(sent[i]), 32'h31 + 32'(i));
    check("burst_empty", 32'(empty), 32'd1);

    // CR handling with and without LF insertion.
    sent.delete();
    hold = 1'b1;
    tick(1'b1, 8'h0D);
    tick(1'b1, 8'h42);
    drain();
`ifdef RX_BUFFER_CRLF_EN
    check("crlf_n", 32'(sent.size()), 32'd3);
    if (sent.size() == 3) begin
      check("crlf_0", 32'(sent[0]), 32'h0D);
      check("crlf_1", 32'(sent[1]), 32'h0A);
      check("crlf_2", 32'(sent[2]), 32'h42);
    end
`else
    check("cr_n", 32'(sent.size()), 32'd2);
    if (sent.size() == 2) begin
      check("cr_0", 32'(sent[0]), 32'h0D);
      check("cr_1", 32'(sent[1]), 32'h42);
    end
`endif

    // Overflow: the seventeenth byte is dropped and never sent.
    sent.delete();
    hold = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 8'h60 + 8'(i));
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    drain();
    check("ovf_sent_n", 32'(sent.size()), 32'd16);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full plus pop: a write on the start edge is accepted.
    do_reset();
    sent.delete();
    hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'h80 + 8'(i));
    hold = 1'b0;
    tick(1'b1, 8'h7A);
    check("fp_start", 32'(tx_start), 32'd1);
    check("fp_count", 32'(count), 32'd16);
    check("fp_overflow", 32'(overflow), 32'd0);
    drain();
    check("fp_sent_n", 32'(sent.size()), 32'd17);
    if (sent.size() == 17) check("fp_last", 32'(sent[16]), 32'h7A);

    // Reset while a start is pending.
    hold = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h51 + 8'(i));
    hold = 1'b0;
    for (int i = 0; i < 10 && !tx_start; i++) tick(1'b0, 8'h00);
    check("mr_start_seen", 32'(tx_start), 32'd1);
    do_reset();
    sent.delete();
    repeat (12) tick(1'b0, 8'h00);
    check("mr_no_starts", 32'(sent.size()), 32'd0);

    // Randomized traffic with random transmitter back-pressure.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) hold = !hold;
      tick(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
